// File: rtl/data_sram_resp.sv
// data_sram_resp: data SRAM responder with byte-lane store, programmable latency and busy/stall output
module data_sram_resp #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic        resp_write,
  output logic        resp_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] off, rd_word, p_data, src_data;
  logic [DEPTH_LOG2-1:0] idx;
  logic in_range, accept, p_write, p_err, src_write, src_err, unused;
  assign off = data_sram_addr - BASE_ADDR;
  assign in_range = off[31:DEPTH_LOG2+2] == '0;
  assign idx = off[DEPTH_LOG2+1:2];
  assign unused = ^off[1:0];
  assign rd_word = in_range ? mem[idx] : '0;
  assign busy = state == WAIT;
  assign resp_valid = state == RESP;
  assign accept = data_sram_en && !busy;
  assign src_data = busy ? p_data : rd_word;
  assign src_write = busy ? p_write : |data_sram_we;
  assign src_err = busy ? p_err : !in_range;
  // next state: WAIT counts down to RESP; IDLE and RESP both accept new requests
  always_comb begin
    state_nxt = busy ? (cnt == 4'd0 ? RESP : WAIT) : accept ? (LATENCY == 1 ? RESP : WAIT) : IDLE;
    cnt_nxt = busy ? (cnt == 4'd0 ? cnt : cnt - 4'd1) : accept ? CNT_INIT : cnt;
  end
  // state and wait counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  // capture the accepted request, then present it on the edge entering RESP
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_data <= '0;
      p_write <= 1'b0;
      p_err <= 1'b0;
      data_sram_rdata <= '0;
      resp_write <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      if (accept) begin
        p_data <= rd_word;
        p_write <= |data_sram_we;
        p_err <= !in_range;
      end
      if (state_nxt == RESP) begin
        resp_write <= src_write;
        resp_err <= src_err;
        if (!src_write) data_sram_rdata <= src_data;
      end
    end
  end
  // backing store, byte-lane writes at the acceptance edge; contents survive reset
  always_ff @(posedge clk) begin
    if (resetn && accept && in_range)
      for (int i = 0; i < 4; i++)
        if (data_sram_we[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: randomized transaction-level check of data_sram_resp at LATENCY 1 and 4
module tb_data_sram_resp;
  localparam logic [31:0] BASE = 32'h1c000000;
  logic clk = 0, resetn = 0;
  logic en [2];
  logic [3:0] we [2];
  logic [31:0] ad [2], wd [2], rdata [2];
  logic rv [2], rw [2], re [2], bsy [2];
  logic [31:0] mm [2][1024];
  logic [31:0] last [2];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  data_sram_resp #(.LATENCY(1)) u1 (.clk(clk), .resetn(resetn), .data_sram_en(en[0]), .data_sram_we(we[0]),
    .data_sram_addr(ad[0]), .data_sram_wdata(wd[0]), .data_sram_rdata(rdata[0]), .resp_valid(rv[0]),
    .resp_write(rw[0]), .resp_err(re[0]), .busy(bsy[0]));
  data_sram_resp #(.LATENCY(4)) u4 (.clk(clk), .resetn(resetn), .data_sram_en(en[1]), .data_sram_we(we[1]),
    .data_sram_addr(ad[1]), .data_sram_wdata(wd[1]), .data_sram_rdata(rdata[1]), .resp_valid(rv[1]),
    .resp_write(rw[1]), .resp_err(re[1]), .busy(bsy[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one complete transaction on instance k; expectation comes from the array model
  task automatic xact(input int k, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off, ed;
    logic inr;
    int lat, n;
    lat = k ? 4 : 1;
    off = a - BASE;
    inr = off[31:12] == 0;
    if (w != 0 && inr)
      for (int i = 0; i < 4; i++)
        if (w[i]) mm[k][off[11:2]][8*i +: 8] = d[8*i +: 8];
    ed = (w != 0) ? last[k] : (inr ? mm[k][off[11:2]] : 32'h0);
    if (w == 0) last[k] = ed;
    @(negedge clk);
    en[k] = 1; we[k] = w; ad[k] = a; wd[k] = d;
    n = 0;
    while (bsy[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    en[k] = 0; we[k] = 4'($urandom); wd[k] = $urandom;
    n = 1;
    while (!rv[k] && n < 20) begin
      check("busy_wait", bsy[k], lat > 1);
      @(negedge clk);
      n++;
    end
    check("latency", n, lat);
    check("resp_write", rw[k], w != 0);
    check("resp_err", re[k], !inr);
    check("rdata", rdata[k], ed);
    @(negedge clk);
    check("single_pulse", rv[k], 0);
    check("rdata_hold", rdata[k], ed);
  endtask

  initial begin
    logic [31:0] ea, eb, a;
    logic [3:0] w;
    int k;
    for (int i = 0; i < 2; i++) begin
      en[i] = 0; we[i] = 0; ad[i] = 0; wd[i] = 0; last[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_rdata", rdata[i], 0);
      check("rst_valid", rv[i], 0);
      check("rst_write", rw[i], 0);
      check("rst_err", re[i], 0);
      check("rst_busy", bsy[i], 0);
    end
    resetn = 1;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 16; i++) xact(j, 4'hf, BASE + 32'(4 * i), 32'(i));
      xact(j, 4'hf, BASE + 32'd4092, $urandom);
    end
    xact(0, 4'hf, 32'h1c000010, 32'hdeadbeef);
    xact(0, 4'h0, 32'h1c000010, 0);
    check("tp_read", rdata[0], 32'hdeadbeef);
    xact(0, 4'hf, 32'h1c000020, 32'h11223344);
    xact(0, 4'b0101, 32'h1c000020, 32'haabbccdd);
    xact(0, 4'h0, 32'h1c000020, 0);
    check("tp_lanes", rdata[0], 32'h11bb33dd);
    // back-to-back reads at LATENCY 1
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("b2b_valid", rv[0], 1);
        check("b2b_rdata", rdata[0], 32'(i - 1));
        check("b2b_busy", bsy[0], 0);
      end
      en[0] = i < 4; we[0] = 0; ad[0] = BASE + 32'(4 * i);
    end
    last[0] = 32'd3;
    @(negedge clk);
    check("b2b_end", rv[0], 0);
    // LATENCY 4 with a second request held while busy
    ea = mm[1][5]; eb = mm[1][6];
    @(negedge clk);
    en[1] = 1; we[1] = 0; ad[1] = BASE + 32'd20;
    @(negedge clk);
    ad[1] = BASE + 32'd24;
    for (int n = 1; n <= 3; n++) begin
      check("held_busy", bsy[1], 1);
      check("held_novalid", rv[1], 0);
      @(negedge clk);
    end
    check("held_valid_a", rv[1], 1);
    check("held_busy_a", bsy[1], 0);
    check("held_rdata_a", rdata[1], ea);
    @(negedge clk);
    en[1] = 0;
    for (int n = 1; n <= 3; n++) begin
      check("held_busy_b", bsy[1], 1);
      @(negedge clk);
    end
    check("held_valid_b", rv[1], 1);
    check("held_rdata_b", rdata[1], eb);
    last[1] = eb;
    @(negedge clk);
    check("held_end", rv[1], 0);
    // out-of-range accesses on both instances
    for (int j = 0; j < 2; j++) begin
      xact(j, 4'h0, 32'h1c001000, 0);
      check("oor_rdata", rdata[j], 0);
      xact(j, 4'hf, 32'h1bfffffc, 32'h5a5a5a5a);
      xact(j, 4'h0, 32'h1c000ffc, 0);
    end
    // reset two cycles into a LATENCY 4 wait
    @(negedge clk);
    en[1] = 1; we[1] = 0; ad[1] = BASE + 32'd28;
    @(negedge clk);
    en[1] = 0;
    @(negedge clk);
    resetn = 0;
    #1;
    check("rst_mid_busy", bsy[1], 0);
    check("rst_mid_valid", rv[1], 0);
    @(negedge clk);
    resetn = 1;
    last[0] = 0; last[1] = 0;
    check("rst_mid_rdata", rdata[1], 0);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("rst_no_resp", rv[1], 0);
    end
    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      k = $urandom % 2;
      case ($urandom % 4)
        0, 1: a = BASE + 32'(4 * ($urandom % 16)) + 32'($urandom % 4);
        2: a = BASE + 32'd4092;
        default: a = ($urandom % 2) ? BASE + 32'd4096 + 32'(4 * ($urandom % 1000)) : BASE - 32'(4 * (1 + $urandom % 8));
      endcase
      w = ($urandom % 2) ? 4'h0 : 4'($urandom);
      xact(k, w, a, $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder (slave) end of the pipeline's data SRAM request interface: en/we/addr/wdata in, read data and completion status out.
- Holds a word-addressed backing store with byte-lane writes and a programmable access latency.
- Drives a busy signal that feeds the pipeline stall input.
- Sits between the EXE/MEM request registers and the MEM/WB load path; it replaces the ideal single-cycle SRAM for latency and stall testing.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words in the store (1024 words by default).
- LATENCY, 1, cycles from request acceptance to response (legal range 1..15).
- BASE_ADDR, 32'h1c000000, byte address that maps to word 0.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- data_sram_en  in  1  request strobe.
- data_sram_we  in  4  byte-lane write enables; 0 means read, nonzero means write.
- data_sram_addr  in  32  byte address; bits [1:0] are ignored.
- data_sram_wdata  in  32  store data; lane i is bits [8i+7:8i].
- data_sram_rdata  out  32  read data, valid while resp_valid=1 and resp_write=0.
- resp_valid  out  1  one-cycle completion pulse for each accepted request.
- resp_write  out  1  1 when the completing request was a write.
- resp_err  out  1  1 when the completing request's address was out of range.
- busy  out  1  responder cannot accept a request this cycle; drives the pipeline stall.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State goes to IDLE. Wait counter = 0.
  - data_sram_rdata=0, resp_valid=0, resp_write=0, resp_err=0, busy=0.
  - Store contents are not reset.
- Acceptance:
  - A request is accepted at a rising edge when data_sram_en=1 and busy=0.
  - Requests presented while busy=1 are ignored; the initiator must hold them.
- Address decode:
  - off = addr - BASE_ADDR (32-bit wrap).
  - In range iff off[31:DEPTH_LOG2+2] == 0. Word index = off[DEPTH_LOG2+1:2].
- Writes:
  - The store is updated at the acceptance edge, only for lanes with we[i]=1; other lanes keep their values.
  - Out-of-range writes modify nothing.
- Reads:
  - The word is captured at the acceptance edge.
  - A write accepted in an earlier cycle is always visible to a later read (no stale data).
  - Out-of-range reads return 0.
- States:
  - IDLE: nothing outstanding.
  - WAIT: counter running; busy=1.
  - RESP: outputs are presented; busy=0.
- Transitions:
  - On acceptance with LATENCY=1: go to RESP.
  - On acceptance with LATENCY>1: go to WAIT with counter = LATENCY-2.
  - WAIT: decrement each cycle; at 0 go to RESP.
  - RESP with no new acceptance: go to IDLE.
  - RESP with a new acceptance: the same transition as an accept from IDLE. With LATENCY=1 this gives back-to-back, one request per cycle.
- Latency: resp_valid is high in exactly one cycle, LATENCY cycles after the acceptance edge. In that cycle resp_write, resp_err and data_sram_rdata describe the completing request.
- Output hold:
  - data_sram_rdata holds its last value when resp_valid=0.
  - For write completions, rdata is unchanged.
- busy = (state == WAIT). busy is a registered output with no combinational path from data_sram_en.
- data_sram_we is ignored when data_sram_en=0.
- Reset asserted mid-operation (WAIT or RESP): the outstanding request is dropped and no resp_valid follows. A write already applied at acceptance stays applied.

Test Plan:
- LATENCY=1:
  - Write we=4'hf, addr=32'h1c000010, wdata=32'hdeadbeef. Next cycle expect resp_valid=1, resp_write=1.
  - Then read the same address. Next cycle expect rdata=32'hdeadbeef, resp_write=0, resp_err=0.
- Byte lanes:
  - Write 32'h11223344 to 32'h1c000020 with we=4'hf.
  - Then write 32'haabbccdd with we=4'b0101.
  - Read back; expect 32'h11bb33dd.
- LATENCY=4: read accepted at edge N.
  - Expect busy=1 for 3 cycles after edge N, then resp_valid=1 in cycle N+4 with busy=0.
  - A second en held throughout is accepted only at the first edge with busy=0.
- LATENCY=1 back-to-back: reads on 4 consecutive cycles to words 0..3 (preloaded 0,1,2,3).
  - Expect 4 consecutive resp_valid pulses with rdata 0,1,2,3.
  - busy stays 0 throughout.
- Out-of-range (DEPTH_LOG2=10):
  - Read 32'h1c001000 → resp_err=1, rdata=0.
  - Write 32'h1bfffffc → resp_err=1; word 1023 unchanged.
- Reset mid-WAIT (LATENCY=4): drop resetn for 1 cycle two cycles after acceptance.
  - Expect busy=0 and resp_valid=0 immediately, and no later response.
